// File: rtl/seg7_pkg.sv
// Segment patterns (active-low, g..a), converter state type and width constants
// shared by the seven-segment scan controller and its BCD engine.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE
  } conv_state_t;

  // Codes 10..15 never come out of the converter; they show as a dark digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_dabble.sv
// Serial double-dabble binary-to-BCD engine: load, then FIELD_W add-3/shift steps.
// o_done strobes during the last shift step; nibbles are valid the cycle after.
module seg7_dabble
  import seg7_pkg::*;
#(
  parameter int FIELD_W = 6
) (
  input  logic               clk_c,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [FIELD_W-1:0] i_bin,
  output logic               o_done,
  output logic [NIB_W-1:0]   o_tens,
  output logic [NIB_W-1:0]   o_units
);

  localparam int CNT_W = $clog2(FIELD_W);
  localparam int SR_W  = 2 * NIB_W + FIELD_W;

  logic [FIELD_W-1:0] r_bin;
  logic [NIB_W-1:0]   r_tens;
  logic [NIB_W-1:0]   r_units;
  logic [CNT_W-1:0]   r_cnt;

  logic [NIB_W-1:0]   w_tens_adj;
  logic [NIB_W-1:0]   w_units_adj;
  logic [SR_W-1:0]    w_shifted;

  assign w_units_adj = (r_units >= 4'd5) ? r_units + 4'd3 : r_units;
  assign w_tens_adj  = (r_tens  >= 4'd5) ? r_tens  + 4'd3 : r_tens;
  assign w_shifted   = {w_tens_adj, w_units_adj, r_bin} << 1;

  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_bin   <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_bin   <= i_bin;
      r_tens  <= '0;
      r_units <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      {r_tens, r_units, r_bin} <= w_shifted;
      r_cnt                    <= r_cnt + 1'b1;
    end
  end

  assign o_done  = i_shift && (r_cnt == CNT_W'(FIELD_W - 1));
  assign o_tens  = r_tens;
  assign o_units = r_units;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: round-robin BCD conversion of changed fields and anode scan.
// Optional macro SEG7_LEADING_BLANK_EN blanks a tens digit of zero.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS  = 3,
  parameter int FIELD_W     = 6,
  parameter int NUM_ANODES  = 8,
  parameter int REFRESH_DIV = 4165
) (
  input  logic                          clk_c,
  input  logic                          rst_n,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic [SEG_W-1:0]              catodo,
  output logic [NUM_ANODES-1:0]         anodo,
  output logic                          conv_busy
);

  localparam int NUM_DIGITS = 2 * NUM_FIELDS;
  localparam int DIV_W      = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
  localparam int DIG_W      = $clog2(NUM_DIGITS);
  localparam int P_W        = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  // Refresh divider and scan state
  logic [DIV_W-1:0]      r_div;
  logic [DIG_W-1:0]      r_d;
  logic [NUM_ANODES-1:0] r_anodo;
  logic [SEG_W-1:0]      r_catodo;
  logic                  w_tick;
  logic [P_W-1:0]        w_sel_field;
  logic [NIB_W-1:0]      w_nib;
  logic [SEG_W-1:0]      w_seg;

  // Converter state
  conv_state_t                          r_state;
  conv_state_t                          w_state_nxt;
  logic [P_W-1:0]                       r_p;
  logic [NUM_FIELDS-1:0][FIELD_W-1:0]   r_shadow;
  logic [NUM_FIELDS-1:0][NIB_W-1:0]     r_tens;
  logic [NUM_FIELDS-1:0][NIB_W-1:0]     r_units;
  logic [FIELD_W-1:0]                   w_cur_field;
  logic [P_W-1:0]                       w_p_inc;
  logic                                 w_load;
  logic                                 w_shift;
  logic                                 w_store;
  logic                                 w_p_adv;
  logic                                 w_done;
  logic [NIB_W-1:0]                     w_conv_tens;
  logic [NIB_W-1:0]                     w_conv_units;

  assign w_tick = (r_div == DIV_W'(REFRESH_DIV));

  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_sel_field = P_W'(r_d >> 1);
  assign w_nib       = r_d[0] ? r_tens[w_sel_field] : r_units[w_sel_field];

  always_comb begin
    w_seg = seg_decode(w_nib);
`ifdef SEG7_LEADING_BLANK_EN
    if (r_d[0] && (w_nib == '0)) begin
      w_seg = SEG_BLANK;
    end
`endif
  end

  // Anode and segments load on the same edge, so a new anode never shows the previous digit.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_d      <= '0;
      r_anodo  <= '1;
      r_catodo <= SEG_BLANK;
    end else if (w_tick) begin
      r_anodo  <= ~(NUM_ANODES'(1) << r_d);
      r_catodo <= w_seg;
      r_d      <= (r_d == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_d + 1'b1;
    end
  end

  assign anodo  = r_anodo;
  assign catodo = r_catodo;

  assign w_cur_field = fields[r_p*FIELD_W +: FIELD_W];
  assign w_p_inc     = (r_p == P_W'(NUM_FIELDS - 1)) ? '0 : r_p + 1'b1;

  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_store     = 1'b0;
    w_p_adv     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cur_field != r_shadow[r_p]) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_p_adv = 1'b1;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_done) begin
          w_state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        w_store     = 1'b1;
        w_p_adv     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The shadow takes the value actually converted, so a change during SHIFT is caught next visit.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_p      <= '0;
      r_shadow <= '0;
      r_tens   <= '0;
      r_units  <= '0;
    end else begin
      if (w_load) begin
        r_shadow[r_p] <= w_cur_field;
      end
      if (w_store) begin
        r_tens[r_p]  <= w_conv_tens;
        r_units[r_p] <= w_conv_units;
      end
      if (w_p_adv) begin
        r_p <= w_p_inc;
      end
    end
  end

  seg7_dabble #(
    .FIELD_W (FIELD_W)
  ) u_dabble (
    .clk_c   (clk_c),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_bin   (w_cur_field),
    .o_done  (w_done),
    .o_tens  (w_conv_tens),
    .o_units (w_conv_units)
  );

  assign conv_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed plus randomized bench for seg7_scan_ctrl with a fast refresh divider.
module tb_seg7_scan_ctrl;

  localparam int NF = 3;
  localparam int FW = 6;
  localparam int NA = 8;
  localparam int RD = 1;
  localparam int ND = 2 * NF;

  logic              clk_c = 1'b0;
  logic              rst_n = 1'b1;
  logic [NF*FW-1:0]  fields = '0;
  logic [6:0]        catodo;
  logic [NA-1:0]     anodo;
  logic              conv_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_c = ~clk_c;

  seg7_scan_ctrl #(
    .NUM_FIELDS  (NF),
    .FIELD_W     (FW),
    .NUM_ANODES  (NA),
    .REFRESH_DIV (RD)
  ) dut (
    .clk_c     (clk_c),
    .rst_n     (rst_n),
    .fields    (fields),
    .catodo    (catodo),
    .anodo     (anodo),
    .conv_busy (conv_busy)
  );

  task automatic step();
    @(posedge clk_c);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digit of the field value, mapped through active-high gfedcba patterns.
  function automatic logic [6:0] exp_seg(input int digit, input logic [NF*FW-1:0] f);
    logic [6:0] on_pat [0:9];
    int v;
    int dig;
    on_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    v   = int'(f[(digit/2)*FW +: FW]);
    dig = (digit % 2 == 1) ? v / 10 : v % 10;
`ifdef SEG7_LEADING_BLANK_EN
    if (digit % 2 == 1 && dig == 0) return 7'h7F;
`endif
    return ~on_pat[dig];
  endfunction

  task automatic scan_check(input int cycles);
    int zeros;
    int idx;
    for (int c = 0; c < cycles; c++) begin
      step();
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < ND; i++) begin
        if (anodo[i] == 1'b0) begin
          zeros++;
          idx = i;
        end
      end
      check("scan_onehot", zeros, 1);
      check("scan_unused_anodes", {30'd0, anodo[NA-1:ND]}, 32'h3);
      if (zeros == 1) check($sformatf("scan_digit%0d", idx), {25'd0, catodo}, {25'd0, exp_seg(idx, fields)});
    end
  endtask

  task automatic measure(input int cycles, output int pulses, output int minl,
                         output int maxl, output int lasthi);
    int run;
    pulses = 0; minl = 1000; maxl = 0; lasthi = 0; run = 0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (conv_busy) begin
        run++;
        lasthi = k;
      end else if (run > 0) begin
        pulses++;
        if (run < minl) minl = run;
        if (run > maxl) maxl = run;
        run = 0;
      end
    end
    if (run > 0) begin
      pulses++;
      if (run < minl) minl = run;
      if (run > maxl) maxl = run;
    end
  endtask

  task automatic wait_busy(input bit level, input string tag);
    int n;
    n = 0;
    while (conv_busy !== level && n < 60) begin
      step();
      n++;
    end
    check(tag, {31'd0, conv_busy}, {31'd0, level});
  endtask

  initial begin
    int pulses, minl, maxl, lasthi, t;
    logic [NA-1:0] exp_an;
    logic [6:0]    exp_cat;

    // Asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_catodo", {25'd0, catodo}, 32'h7F);
    check("rst_anodo", {24'd0, anodo}, 32'hFF);
    check("rst_busy", {31'd0, conv_busy}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // Scan walk with all fields zero: first tick after RD+1 clocks
    for (int n = 1; n <= 16; n++) begin
      step();
      t       = n / (RD + 1);
      exp_an  = '1;
      exp_cat = 7'h7F;
      if (t > 0) begin
        exp_an[(t-1) % ND] = 1'b0;
        exp_cat            = exp_seg((t-1) % ND, fields);
      end
      check($sformatf("walk_anodo_n%0d", n), {24'd0, anodo}, {24'd0, exp_an});
      check($sformatf("walk_catodo_n%0d", n), {25'd0, catodo}, {25'd0, exp_cat});
      check("walk_no_conv", {31'd0, conv_busy}, 32'd0);
    end

    // Three changed fields: three 8-clock conversions, all stored within 27 clocks
    fields = {6'd23, 6'd7, 6'd59};
    measure(40, pulses, minl, maxl, lasthi);
    check("conv3_pulses", pulses, 3);
    check("conv3_minlen", minl, FW + 2);
    check("conv3_maxlen", maxl, FW + 2);
    check("conv3_deadline", {31'd0, lasthi <= NF*(FW+3) - 1}, 32'd1);
    scan_check(12);

    // Change field0 again while it is mid-SHIFT
    fields[FW-1:0] = 6'd44;
    wait_busy(1'b1, "chg_busy_rise");
    repeat (3) step();
    fields[FW-1:0] = 6'd0;
    wait_busy(1'b0, "chg_busy_fall");
    check("chg_first_tens", {28'd0, dut.r_tens[0]}, 32'd4);
    check("chg_first_units", {28'd0, dut.r_units[0]}, 32'd4);
    measure(30, pulses, minl, maxl, lasthi);
    check("chg_second_pulses", pulses, 1);
    check("chg_second_len", maxl, FW + 2);
    check("chg_final_tens", {28'd0, dut.r_tens[0]}, 32'd0);
    check("chg_final_units", {28'd0, dut.r_units[0]}, 32'd0);
    scan_check(12);

    // Random field updates, observed on the scanned outputs
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < NF; k++) begin
        if ($urandom_range(0, 1) == 1) fields[k*FW +: FW] = FW'($urandom_range(0, 63));
      end
      repeat (NF*(FW+3) + 3) step();
      check("rand_idle", {31'd0, conv_busy}, 32'd0);
      scan_check(12);
    end

    // Reset in the middle of a conversion
    fields = {6'd12, 6'd34, 6'd56};
    repeat (30) step();
    fields[2*FW-1:FW] = 6'd50;
    wait_busy(1'b1, "midrst_busy_rise");
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_catodo", {25'd0, catodo}, 32'h7F);
    check("midrst_anodo", {24'd0, anodo}, 32'hFF);
    check("midrst_busy", {31'd0, conv_busy}, 32'd0);
    check("midrst_tens", {20'd0, dut.r_tens}, 32'd0);
    check("midrst_units", {20'd0, dut.r_units}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    measure(40, pulses, minl, maxl, lasthi);
    check("postrst_pulses", pulses, 3);
    scan_check(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
